// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, with a single-cycle fast path for the division corner cases.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_valid,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            inst_mul,
    input  logic            inst_mulh,
    input  logic            inst_mulhsu,
    input  logic            inst_mulhu,
    input  logic            inst_div,
    input  logic            inst_divu,
    input  logic            inst_rem,
    input  logic            inst_remu,
    input  logic            md_kill,
    output logic [XLEN-1:0] md_result,
    output logic            md_done,
    output logic            md_stall,
    output logic            md_busy,
    output logic [1:0]      md_state
);
    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     counter;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   b_reg;
    logic              neg, is_div, is_rem, is_hi;

    logic              any_flag, req, sgn_a, sgn_b, neg_in, div_in, rem_in, hi_in, fast;
    logic              load_start, load_res, ge;
    logic [XLEN-1:0]   a_abs, b_abs, min_int, start_b, res_val;
    logic [2*XLEN-1:0] start_acc, fast_acc, mul_step, div_step, acc_step;
    logic [XLEN:0]     msum, rsh;

    // Sign-fix and field select; v is {hi,lo} for multiply and {rem,quot} for divide.
    function automatic logic [XLEN-1:0] pick(input logic [2*XLEN-1:0] v, input logic ng,
                                             input logic dv, input logic rm, input logic hi);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   h;
        p = ng ? -v : v;
        h = rm ? v[2*XLEN-1:XLEN] : v[XLEN-1:0];
        if (dv) return ng ? -h : h;
        return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    assign min_int  = {1'b1, {(XLEN-1){1'b0}}};
    assign any_flag = inst_mul | inst_mulh | inst_mulhsu | inst_mulhu |
                      inst_div | inst_divu | inst_rem | inst_remu;
    assign req      = md_valid & any_flag & ~md_kill;
    assign sgn_a    = inst_mul | inst_mulh | inst_mulhsu | inst_div | inst_rem;
    assign sgn_b    = inst_mul | inst_mulh | inst_div | inst_rem;
    assign a_abs    = (sgn_a && op1[XLEN-1]) ? -op1 : op1;
    assign b_abs    = (sgn_b && op2[XLEN-1]) ? -op2 : op2;
    assign div_in   = inst_div | inst_divu | inst_rem | inst_remu;
    assign rem_in   = inst_rem | inst_remu;
    assign hi_in    = inst_mulh | inst_mulhsu | inst_mulhu;
    assign neg_in   = (inst_mul | inst_mulh | inst_div) ? (op1[XLEN-1] ^ op2[XLEN-1]) :
                      (inst_mulhsu | inst_rem)          ? op1[XLEN-1] : 1'b0;
    assign fast     = div_in & ((op2 == '0) |
                      ((inst_div | inst_rem) & (op1 == min_int) & (op2 == '1)));
    // Divide-by-zero yields quot=all-ones and rem=dividend; overflow yields quot=MIN, rem=0.
    assign fast_acc  = (op2 == '0) ? {op1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, min_int};
    assign start_acc = div_in ? {{XLEN{1'b0}}, a_abs} : {{XLEN{1'b0}}, b_abs};
    assign start_b   = div_in ? b_abs : a_abs;

    // Multiply: upper half accumulates, lower half shifts the multiplier out.
    assign msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_reg} : '0);
    assign mul_step = {msum, acc[XLEN-1:1]};
    assign rsh      = acc[2*XLEN-1:XLEN-1];
    assign ge       = (rsh >= {1'b0, b_reg});
    assign div_step = {(ge ? (rsh[XLEN-1:0] - b_reg) : rsh[XLEN-1:0]), acc[XLEN-2:0], ge};
    assign acc_step = is_div ? div_step : mul_step;

    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        load_res   = 1'b0;
        res_val    = pick(acc_step, neg, is_div, is_rem, is_hi);
        case (state)
            IDLE: begin
                if (req) begin
                    load_start = 1'b1;
                    if (fast) begin
                        state_nxt = DONE;
                        load_res  = 1'b1;
                        res_val   = pick(fast_acc, 1'b0, 1'b1, rem_in, 1'b0);
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (md_kill) begin
                    state_nxt = IDLE;
                end else if (counter == '0) begin
                    state_nxt = DONE;
                    load_res  = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign md_stall = ((state == IDLE) & req) | (state == CALC);
    assign md_done  = (state == DONE) & ~md_kill;
    assign md_busy  = (state != IDLE);
    assign md_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            acc       <= '0;
            b_reg     <= '0;
            neg       <= 1'b0;
            is_div    <= 1'b0;
            is_rem    <= 1'b0;
            is_hi     <= 1'b0;
            md_result <= '0;
        end else begin
            state <= state_nxt;
            if (load_start) begin
                acc     <= start_acc;
                b_reg   <= start_b;
                neg     <= neg_in;
                is_div  <= div_in;
                is_rem  <= rem_in;
                is_hi   <= hi_in;
                counter <= CW'(ITERS - 1);
            end else if (state == CALC) begin
                acc <= acc_step;
                if (counter != '0) counter <= counter - 1'b1;
            end
            if (load_res) md_result <= res_val;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random operations
// compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        md_valid = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [7:0]  flags = '0;
    logic        md_kill = 1'b0;
    logic [31:0] md_result;
    logic        md_done, md_stall, md_busy;
    logic [1:0]  md_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;
    logic [31:0] last_res = '0;

    localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
    localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .md_valid(md_valid), .op1(op1), .op2(op2),
        .inst_mul(flags[0]), .inst_mulh(flags[1]), .inst_mulhsu(flags[2]), .inst_mulhu(flags[3]),
        .inst_div(flags[4]), .inst_divu(flags[5]), .inst_rem(flags[6]), .inst_remu(flags[7]),
        .md_kill(md_kill), .md_result(md_result), .md_done(md_done), .md_stall(md_stall),
        .md_busy(md_busy), .md_state(md_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (md_valid) assert ($countones(flags) <= 1) else $error("decode flags not one-hot: %b", flags);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model straight from the RV32M definitions
    function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        case (op)
            OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            OP_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input int op, input logic [31:0] a, input logic [31:0] b);
        if (op < OP_DIV) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // driver: present one M instruction, hold it while stalled, check result and timing
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b);
        int          lat, gaps, exp_lat;
        bit          seen;
        logic [31:0] exp_q[$];
        exp_q.push_back(ref_model(op, a, b));
        exp_lat = is_fast(op, a, b) ? 1 : 33;
        @(negedge clk);
        md_valid = 1'b1;
        flags    = 8'(1 << op);
        op1      = a;
        op2      = b;
        #1;
        check_eq("stall_cycle0", 32'(md_stall), 32'd1);
        lat  = 0;
        gaps = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (md_done) seen = 1'b1;
            else if (!md_stall) gaps++;
        end
        check_eq($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat));
        check_eq($sformatf("result op%0d %h,%h", op, a, b), md_result, exp_q[0]);
        check_eq("stall_gap", 32'(gaps), 32'd0);
        check_eq("stall_in_done", 32'(md_stall), 32'd0);
        last_res      = exp_q.pop_front();
        last_done_cyc = cyc;
        md_valid = 1'b0;
        flags    = '0;
    endtask

    initial begin
        int          d1, d2, stalls, dones, op;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_result", md_result, 32'h0);
        check_eq("reset_done", 32'(md_done), 32'd0);
        check_eq("reset_busy", 32'(md_busy), 32'd0);
        check_eq("reset_stall", 32'(md_stall), 32'd0);
        rst = 1'b0;

        // directed cases
        run_op(OP_MUL,    32'd7, 32'hFFFF_FFFD);
        check_eq("mul_7x-3", last_res, 32'hFFFF_FFEB);
        run_op(OP_MULH,   32'd7, 32'hFFFF_FFFD);
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_DIV,    32'hFFFF_FFEC, 32'd3);
        run_op(OP_REM,    32'hFFFF_FFEC, 32'd3);
        run_op(OP_DIVU,   32'd100, 32'd7);
        run_op(OP_REMU,   32'd100, 32'd7);
        run_op(OP_DIV,    32'd5, 32'd0);
        run_op(OP_REMU,   32'd5, 32'd0);
        run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF);

        // result holds while idle
        repeat (3) @(negedge clk);
        check_eq("result_hold", md_result, last_res);

        // kill in CALC cycle 10
        @(negedge clk);
        md_valid = 1'b1; flags = 8'(1 << OP_DIVU); op1 = 32'd1000; op2 = 32'd7;
        repeat (10) @(negedge clk);
        md_kill = 1'b1;
        md_valid = 1'b0; flags = '0;
        #1 check_eq("kill_no_done", 32'(md_done), 32'd0);
        @(negedge clk);
        md_kill = 1'b0;
        check_eq("kill_busy", 32'(md_busy), 32'd0);
        check_eq("kill_stall", 32'(md_stall), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) dones++;
        end
        check_eq("kill_done_count", 32'(dones), 32'd0);
        check_eq("kill_result", md_result, last_res);

        // reset in CALC cycle 20
        @(negedge clk);
        md_valid = 1'b1; flags = 8'(1 << OP_MUL); op1 = 32'd123; op2 = 32'd456;
        repeat (20) @(negedge clk);
        rst = 1'b1; md_valid = 1'b0; flags = '0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_result", md_result, 32'h0);
        check_eq("rst_mid_done", 32'(md_done), 32'd0);
        check_eq("rst_mid_busy", 32'(md_busy), 32'd0);
        check_eq("rst_mid_stall", 32'(md_stall), 32'd0);
        last_res = '0;

        // back-to-back issue intervals
        run_op(OP_DIVU, 32'd100, 32'd7);
        d1 = last_done_cyc;
        run_op(OP_MUL, 32'd9, 32'd11);
        d2 = last_done_cyc;
        check_eq("b2b_interval", 32'(d2 - d1), 32'd34);
        run_op(OP_DIV, 32'd9, 32'd0);
        d1 = last_done_cyc;
        run_op(OP_REM, 32'd9, 32'd0);
        d2 = last_done_cyc;
        check_eq("b2b_fast_interval", 32'(d2 - d1), 32'd2);

        // non-M instruction after done is never stalled
        @(negedge clk);
        md_valid = 1'b1; flags = '0; op1 = $urandom; op2 = $urandom;
        stalls = 0;
        repeat (5) begin
            #1 if (md_stall) stalls++;
            @(negedge clk);
        end
        md_valid = 1'b0;
        check_eq("add_never_stalled", 32'(stalls), 32'd0);

        // random operations
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
                3: b = $urandom_range(1, 9);
                default: ;
            endcase
            run_op(op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the single-cycle ALU in the EX stage.
- Accepts one-hot decoded M-extension flags and operands from ID/EX, then runs a radix-2 shift-add/shift-subtract datapath for 32 iterations.
- Holds the pipeline through `md_stall` until the result is ready.
- Handles the RV32M division special cases in a single-cycle fast path.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERS, 32, number of CALC iterations; must equal XLEN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- md_valid  input  1  ID/EX slot holds a valid instruction
- op1  input  32  rs1 value (post-forwarding)
- op2  input  32  rs2 value (post-forwarding)
- inst_mul, inst_mulh, inst_mulhsu, inst_mulhu  input  1 each  one-hot decode flags
- inst_div, inst_divu, inst_rem, inst_remu  input  1 each  one-hot decode flags
- md_kill  input  1  flush from branch/jump resolution; aborts the operation
- md_result  output  32  result; valid when md_done=1
- md_done  output  1  one-cycle pulse: md_result valid, instruction may retire
- md_stall  output  1  combinational; freeze PC, IF/ID and ID/EX
- md_busy  output  1  registered; state != IDLE

Behaviour:
- Reset (clk edge with rst=1), from any state including mid-operation:
  - state=IDLE, counter=0.
  - md_result=0, md_done=0, md_busy=0.
  - Internal accumulator/quotient registers cleared.
- `req` = md_valid & (OR of the 8 flags) & ~md_kill.
- States: IDLE, CALC, DONE.
- IDLE, req=1 (cycle 0):
  - Latch op type and operands.
  - Record result sign:
    - MUL/MULH: op1[31]^op2[31].
    - MULHSU: op1[31].
    - DIV: op1[31]^op2[31].
    - REM: op1[31].
    - Unsigned ops: 0.
  - Store absolute values (signed operands only; MULHSU takes abs of op1 only).
  - Fast path, next state DONE:
    - DIV/DIVU with op2==0: quotient=32'hFFFF_FFFF.
    - REM/REMU with op2==0: remainder=op1.
    - DIV/REM with op1==32'h8000_0000 and op2==32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
  - Otherwise: counter=ITERS-1, next state CALC.
- CALC, one iteration per cycle:
  - Multiply: 64-bit product accumulator; add multiplicand if the multiplier LSB is 1, then shift right 1.
  - Divide: restoring; shift {rem,quot} left 1; if rem>=divisor, subtract and set quot LSB.
  - At counter==0, next state DONE; otherwise decrement.
  - Normal ops therefore take exactly 32 CALC cycles (cycles 1..32).
- DONE (cycle 33 normal, cycle 1 fast path):
  - Apply sign fix: two's-complement negate the 64-bit product or the quotient/remainder if the recorded sign=1.
  - Select output:
    - MUL: low 32 bits.
    - MULH/MULHSU/MULHU: high 32 bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - md_result is registered on entry to DONE; md_done=1 for exactly this cycle.
  - Unconditional transition to IDLE.
- md_result holds its value until the next DONE or reset.
- md_stall:
  - = (IDLE & req) | CALC.
  - Low in DONE, so the instruction advances out of ID/EX on the DONE edge.
  - A back-to-back M instruction is then seen in IDLE on the following cycle.
  - Minimum issue interval: 34 cycles normal, 2 cycles fast path.
- md_kill:
  - In IDLE: suppresses req (no start, no stall).
  - In CALC or DONE: next state IDLE.
  - md_done is forced to 0 in the kill cycle; md_result is not updated.
  - md_kill takes priority over all transitions; rst takes priority over md_kill.
- Non-M instructions, or md_valid=0: the block is inert; md_stall=0.
- More than one flag set is illegal; the bench asserts one-hot.

Test Plan:
- MUL op1=7, op2=-3 (32'hFFFF_FFFD) -> md_stall high cycles 0..32, md_done cycle 33, md_result=32'hFFFF_FFEB; MULH same operands -> 32'hFFFF_FFFF.
- MULHU op1=op2=32'hFFFF_FFFF -> 32'hFFFF_FFFE; MULHSU op1=-1, op2=32'hFFFF_FFFF -> 32'hFFFF_FFFF.
- DIV op1=-20, op2=3 -> 32'hFFFF_FFFA (-6); REM same operands -> 32'hFFFF_FFFE (-2); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV by zero, op1=5 -> md_done in cycle 1, result 32'hFFFF_FFFF; REMU by 0 -> 5; DIV 32'h8000_0000 / -1 -> 32'h8000_0000, md_done cycle 1; REM same operands -> 0.
- md_kill asserted in CALC cycle 10 -> state IDLE next cycle, md_stall drops, no md_done, md_result unchanged; rst in CALC cycle 20 -> all outputs 0 next cycle.
- Back-to-back DIVU then MUL -> second md_done exactly 34 cycles after the first; an ADD following is never stalled once md_done has fired.
